// File: rtl/data_memory_arbiter_pkg.sv
// data_memory_arbiter_pkg
//   Types and constants shared by the data-memory arbiter, the memory
//   model and the decode stage.
//   - arbState_t : arbiter FSM states
//   - memReq_t   : one port's request as presented to the memory
//   - FUNC3_*    : load/store width codes (passed through untouched)
package data_memory_arbiter_pkg;

   typedef enum logic {
      ARB_CPU_PRIORITY = 1'b0,
      ARB_DMA_FORCED   = 1'b1
   } arbState_t;

   typedef struct packed {
      logic        write;
      logic [2:0]  func3;
      logic [31:0] address;
      logic [31:0] data;
   } memReq_t;

   localparam logic [2:0] FUNC3_LB  = 3'b000;
   localparam logic [2:0] FUNC3_LH  = 3'b001;
   localparam logic [2:0] FUNC3_LW  = 3'b010;
   localparam logic [2:0] FUNC3_LBU = 3'b100;
   localparam logic [2:0] FUNC3_LHU = 3'b101;
   localparam logic [2:0] FUNC3_SB  = 3'b000;
   localparam logic [2:0] FUNC3_SH  = 3'b001;
   localparam logic [2:0] FUNC3_SW  = 3'b010;

endpackage

// File: rtl/data_memory_arbiter_starvation_counter.sv
// starvation_counter
//   Counts consecutive cycles a DMA request is pending but not accepted.
//   Ports:
//     clock, reset   : clock, synchronous active-high reset
//     pending        : DMA request is waiting this cycle
//     accepted       : DMA request is accepted this cycle
//     limitReached   : next-cycle count equals LIMIT (force a DMA grant)
module starvation_counter #(
   parameter int LIMIT = 4
) (
   input  logic clock,
   input  logic reset,
   input  logic pending,
   input  logic accepted,
   output logic limitReached
);

   localparam int              CW  = $clog2(LIMIT + 1);
   localparam logic [CW-1:0]   LIM = CW'(LIMIT);

   logic [CW-1:0] count;
   logic [CW-1:0] countNext;

   // A withdrawn or accepted request restarts the wait from zero.
   always_comb begin
      countNext = count;
      if (!pending || accepted)
         countNext = '0;
      else if (count != LIM)
         countNext = count + 1'b1;
   end

   // Looking at the next count lets the FSM enter the forced state right
   // after the LIMIT-th denied cycle.
   assign limitReached = (countNext == LIM);

   always_ff @(posedge clock) begin
      if (reset)
         count <= '0;
      else
         count <= countNext;
   end

endmodule

// File: rtl/data_memory_arbiter.sv
// data_memory_arbiter
//   Shares the single-port data memory between the MEM stage (CPU port,
//   fixed priority, combinational read data) and a DMA/loader port
//   (valid/ready, registered read data one cycle after acceptance).
//   A starvation counter forces one DMA grant after STARVE_LIMIT denied
//   cycles, stalling the CPU for that cycle.
//   Ports:
//     clock, reset                 : clock, synchronous active-high reset
//     cpuReq/Write/Func3/Address/WriteData : CPU request
//     cpuReadData, cpuStall        : CPU load data (comb), hold MEM stage
//     dmaValid/Write/Func3/Address/WriteData : DMA request
//     dmaReady                     : DMA request accepted this cycle
//     dmaReadValid, dmaReadData    : registered DMA load response
//     memoryReadEnable/WriteEnable, func3, memoryAddress, writeData : to memory
//     readData                     : combinational data from memory
module data_memory_arbiter
   import data_memory_arbiter_pkg::*;
#(
   parameter int STARVE_LIMIT = 4
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        cpuReq,
   input  logic        cpuWrite,
   input  logic [2:0]  cpuFunc3,
   input  logic [31:0] cpuAddress,
   input  logic [31:0] cpuWriteData,
   output logic [31:0] cpuReadData,
   output logic        cpuStall,
   input  logic        dmaValid,
   input  logic        dmaWrite,
   input  logic [2:0]  dmaFunc3,
   input  logic [31:0] dmaAddress,
   input  logic [31:0] dmaWriteData,
   output logic        dmaReady,
   output logic        dmaReadValid,
   output logic [31:0] dmaReadData,
   output logic        memoryReadEnable,
   output logic        memoryWriteEnable,
   output logic [2:0]  func3,
   output logic [31:0] memoryAddress,
   output logic [31:0] writeData,
   input  logic [31:0] readData
);

   arbState_t state;
   logic      cpuGrant;
   logic      dmaGrant;
   logic      limitReached;
   memReq_t   cpuPort;
   memReq_t   dmaPort;
   memReq_t   granted;

   assign cpuPort = '{write: cpuWrite, func3: cpuFunc3, address: cpuAddress, data: cpuWriteData};
   assign dmaPort = '{write: dmaWrite, func3: dmaFunc3, address: dmaAddress, data: dmaWriteData};

   // Nothing is granted while reset is held, so the memory sees no access
   // and the CPU stalls on any request.
   always_comb begin
      cpuGrant = 1'b0;
      dmaGrant = 1'b0;
      if (!reset) begin
         if (state == ARB_DMA_FORCED) begin
            dmaGrant = dmaValid;
         end else begin
            cpuGrant = cpuReq;
            dmaGrant = dmaValid && !cpuReq;
         end
      end
   end

   always_comb begin
      granted = '0;
      if (cpuGrant)
         granted = cpuPort;
      else if (dmaGrant)
         granted = dmaPort;
   end

   assign memoryReadEnable  = (cpuGrant || dmaGrant) && !granted.write;
   assign memoryWriteEnable = (cpuGrant || dmaGrant) &&  granted.write;
   assign func3             = granted.func3;
   assign memoryAddress     = granted.address;
   assign writeData         = granted.data;

   assign cpuReadData = (cpuGrant && !cpuWrite) ? readData : 32'h0;
   assign cpuStall    = cpuReq && !cpuGrant;
   assign dmaReady    = dmaGrant;

   starvation_counter #(.LIMIT(STARVE_LIMIT)) u_starve (
      .clock        (clock),
      .reset        (reset),
      .pending      (dmaValid),
      .accepted     (dmaGrant),
      .limitReached (limitReached)
   );

   // Forced state lasts exactly one cycle, whether or not the DMA is
   // still there to take it.
   always_ff @(posedge clock) begin
      if (reset) begin
         state        <= ARB_CPU_PRIORITY;
         dmaReadValid <= 1'b0;
         dmaReadData  <= 32'h0;
      end else begin
         if (state == ARB_DMA_FORCED)
            state <= ARB_CPU_PRIORITY;
         else if (limitReached)
            state <= ARB_DMA_FORCED;

         dmaReadValid <= dmaGrant && !dmaWrite;
         if (dmaGrant && !dmaWrite)
            dmaReadData <= readData;
      end
   end

endmodule

// File: doc/data_memory_arbiter.md
# data_memory_arbiter

Shares the single-port data memory between the pipeline MEM stage (CPU port) and a DMA/loader port. It sits between both requesters and the memory. The CPU has fixed priority. A starvation counter forces a DMA grant after a bounded wait, and the block stalls the pipeline for that cycle. DMA reads are registered and returned one cycle after acceptance; CPU reads stay combinational so MEM-stage timing is unchanged.

## Interface
- STARVE_LIMIT, 4, consecutive denied DMA cycles before a forced DMA grant; legal range ≥1
- clock  in  1  clock
- reset  in  1  synchronous, active-high reset
- cpuReq  in  1  MEM stage requests memory this cycle
- cpuWrite  in  1  1 = store, 0 = load
- cpuFunc3  in  3  load/store width code (LB/LH/LW/LBU/LHU, SB/SH/SW)
- cpuAddress  in  32  byte address
- cpuWriteData  in  32  store data
- cpuReadData  out  32  load data; combinational, valid in the grant cycle
- cpuStall  out  1  CPU request not served this cycle; the pipeline must hold the MEM stage
- dmaValid  in  1  DMA request pending; fields held stable until accepted
- dmaWrite  in  1  1 = store, 0 = load
- dmaFunc3  in  3  width code
- dmaAddress  in  32  byte address
- dmaWriteData  in  32  store data
- dmaReady  out  1  DMA request accepted this cycle (dmaValid && dmaReady)
- dmaReadValid  out  1  one-cycle pulse: dmaReadData holds the load result
- dmaReadData  out  32  registered DMA load data
- memoryReadEnable  out  1  to memory
- memoryWriteEnable  out  1  to memory
- func3  out  3  to memory
- memoryAddress  out  32  to memory
- writeData  out  32  to memory
- readData  in  32  from memory, combinational

## Operation
- FSM states and transitions:
  - ARB_CPU_PRIORITY: the grant goes to the CPU if cpuReq is high, else to the DMA if dmaValid is high, else nobody.
  - ARB_DMA_FORCED: the grant goes to the DMA if dmaValid is high; cpuStall = cpuReq.
  - After any cycle in ARB_DMA_FORCED, the FSM returns to ARB_CPU_PRIORITY.
- Starvation counter, width $clog2(STARVE_LIMIT+1):
  - Increments, saturating, on each cycle with dmaValid && !dmaReady.
  - Clears on DMA acceptance or when dmaValid is low.
  - When the next-cycle count equals STARVE_LIMIT, the FSM moves to ARB_DMA_FORCED.
- Granted port drives memory:
  - memoryReadEnable = !write.
  - memoryWriteEnable = write.
  - func3, memoryAddress and writeData are taken from the granted port.
- No grant: all memory outputs are 0.
- cpuReadData:
  - Equals readData when the CPU is granted for a load.
  - Otherwise 0.
- cpuStall = cpuReq && !cpuGrant.
- DMA read capture:
  - On an accepted DMA load, readData is registered into dmaReadData.
  - dmaReadValid = 1 on the following cycle.
  - dmaReadData holds until the next DMA load completes.
- Accepted DMA store: dmaReadValid stays 0.
- Width handling (sign/zero-extension, sub-word stores) is done entirely by the memory; func3 passes through unchanged.

## Timing
- Reset values:
  - State ARB_CPU_PRIORITY, counter 0.
  - dmaReadValid 0, dmaReadData 0.
- While reset is high:
  - dmaReady = 0.
  - Memory enables = 0.
  - cpuStall = cpuReq.
- Reset mid-operation discards any pending DMA read response: dmaReadValid = 0 in the cycle after reset.
- Latency:
  - CPU access: 0 cycles (same-cycle grant; store commits at the next edge).
  - DMA load data: 1 cycle after acceptance.
  - Worst-case DMA wait: STARVE_LIMIT cycles, granted in the following cycle.
- Example, STARVE_LIMIT=4, cpuReq and dmaValid both held high from cycle 0:
  - Cycles 0–3: CPU served.
  - Cycle 4: DMA served, cpuStall=1.
  - Cycle 5: CPU served, counter restarts.
- dmaValid dropping while in ARB_DMA_FORCED is a protocol violation. The required response is: no grant, FSM returns to ARB_CPU_PRIORITY, counter clears.
- Simultaneous DMA load acceptance and a CPU store to the same word cannot occur, because only one port is granted per cycle.
- Memory arrival order is the grant order.

## Structure
- Shared package:
  - arbState_t enum {ARB_CPU_PRIORITY, ARB_DMA_FORCED}.
  - func3 constants FUNC3_LB/LH/LW/LBU/LHU/SB/SH/SW, shared with the memory and decode stages.
- One sub-module: starvation_counter (parameter LIMIT; inputs pending, accepted; output limitReached).
- Grant mux and FSM live in the top module.

## Test plan
- CPU only: cpuReq=1, cpuWrite=1, cpuFunc3=SW, address 0x10, data 0xDEADBEEF; then a CPU LW from 0x10 → cpuReadData=0xDEADBEEF in the same cycle, cpuStall=0.
- DMA only: dmaValid=1, dmaWrite=0, LB at 0x10 (memory word 0x000000F0) → dmaReady=1 in cycle 0; dmaReadValid=1 with dmaReadData=0xFFFFFFF0 in cycle 1.
- Contention, STARVE_LIMIT=4: both requests held high → dmaReady and cpuStall both high only in cycle 4; repeats in cycle 9.
- DMA request withdrawn after 2 denied cycles → counter reads 0; a new request waits the full 4 cycles again.
- Reset asserted in the cycle after a DMA load is accepted → dmaReadValid=0, dmaReadData=0, dmaReady=0; cpuStall tracks cpuReq during reset.
- Idle, no requests → memoryReadEnable=memoryWriteEnable=0, memoryAddress=0, cpuReadData=0.
